msg_arb_queue: RTL and testbench



---
 rtl/msg_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/msg_arb_queue.sv | 139 +++++++++++++
 tb/tb_msg_arb_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared helpers for the message arbitration queue: index widths, FIFO entry layout,
// FIFO operation encoding and saturating arithmetic.
package msg_pkg;

    function automatic int unsigned ChanIdxWidth(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // FIFO entry is {chan, msg}: the channel sits above the message bits.
    function automatic int unsigned entry_width(input int unsigned cw, input int unsigned ml);
        return cw + ml;
    endfunction

    function automatic int unsigned entry_chan_lsb(input int unsigned ml);
        return ml;
    endfunction

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic longint unsigned sat_add(input longint unsigned a,
                                                input longint unsigned b,
                                                input int unsigned     width);
        longint unsigned max_v;
        longint unsigned sum;
        max_v = (64'd1 << width) - 64'd1;
        sum   = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer,
// then moves the pointer just past the winner.
module rr_arbiter
    import msg_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                req,
    input  logic                        en,
    output logic                        gnt_valid,
    output logic [ChanIdxWidth(N)-1:0]  gnt_idx
);

    localparam int unsigned W = ChanIdxWidth(N);
    localparam logic [W-1:0] LastIdx = W'(N - 1);

    logic [W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0] sel;
    logic         found;
    int unsigned  cand;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= N) cand = cand - N;
            if (!found && req[W'(cand)]) begin
                found = 1'b1;
                sel   = W'(cand);
            end
        end
        gnt_valid = found & en;
        gnt_idx   = sel;
        rr_ptr_d  = rr_ptr_q;
        if (gnt_valid) rr_ptr_d = (sel == LastIdx) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/msg_arb_queue.sv
// Multi-channel message queue: one pending slot per channel, round-robin arbitration
// into a shared FIFO drained over valid/ready, with saturating drop accounting.
module msg_arb_queue
    import msg_pkg::*;
#(
    parameter int unsigned ChanCount    = 4,
    parameter int unsigned MsgLen       = 8,
    parameter int unsigned Depth        = 4,
    parameter int unsigned DropCntWidth = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ChanCount-1:0]                in_trigger,
    input  logic [ChanCount*MsgLen-1:0]         in_msg,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [MsgLen-1:0]                   out_msg,
    output logic [ChanIdxWidth(ChanCount)-1:0]  out_chan,
    output logic [$clog2(Depth):0]              out_level,
    output logic [DropCntWidth-1:0]             drop_count,
    output logic [ChanCount-1:0]                drop_sticky,
    input  logic                                drop_clear
);

    localparam int unsigned CW   = ChanIdxWidth(ChanCount);
    localparam int unsigned AW   = $clog2(Depth);
    localparam int unsigned EW   = entry_width(CW, MsgLen);
    localparam int unsigned CLSB = entry_chan_lsb(MsgLen);
    localparam logic [AW:0] LevelFull = (AW + 1)'(Depth);

    logic [ChanCount-1:0]             pend_q, pend_d;
    logic [ChanCount-1:0][MsgLen-1:0] pmsg_q, pmsg_d;
    logic [EW-1:0]                    mem_q [Depth];
    logic [AW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                      level_q, level_d;
    logic [DropCntWidth-1:0]          dcnt_q, dcnt_d;
    logic [ChanCount-1:0]             sticky_q, sticky_d;

    logic          gnt_valid, push, pop, fifo_room, granted;
    logic [CW-1:0] gnt_idx;
    logic [EW-1:0] head;
    logic [ChanCount-1:0] drop_vec;
    int unsigned   ndrop;
    fifo_op_e      fifo_op;

    assign out_valid = (level_q != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot the grant will write into.
    assign fifo_room = (level_q != LevelFull) | pop;
    assign push      = gnt_valid;

    rr_arbiter #(.N(ChanCount)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend_q),
        .en        (fifo_room),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        pend_d   = pend_q;
        pmsg_d   = pmsg_q;
        drop_vec = '0;
        ndrop    = 0;
        granted  = 1'b0;
        for (int unsigned c = 0; c < ChanCount; c++) begin
            granted = gnt_valid && (gnt_idx == CW'(c));
            if (granted) pend_d[c] = 1'b0;
            if (in_trigger[c]) begin
                if (!pend_q[c] || granted) begin
                    pend_d[c] = 1'b1;
                    pmsg_d[c] = in_msg[c*MsgLen +: MsgLen];
                end else begin
                    drop_vec[c] = 1'b1;
                    ndrop       = ndrop + 1;
                end
            end
        end
        // Clear and a coincident drop: the clear zeroes history, the new drop survives.
        dcnt_d   = DropCntWidth'(sat_add(drop_clear ? 64'd0 : 64'(dcnt_q), 64'(ndrop), DropCntWidth));
        sticky_d = (drop_clear ? '0 : sticky_q) | drop_vec;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        fifo_op  = fifo_op_e'({push, pop});
        unique case (fifo_op)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                level_d  = level_q + 1'b1;
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                level_d  = level_q - 1'b1;
            end
            FIFO_BOTH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            pmsg_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dcnt_q   <= '0;
            sticky_q <= '0;
        end else begin
            pend_q   <= pend_d;
            pmsg_q   <= pmsg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dcnt_q   <= dcnt_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {gnt_idx, pmsg_q[gnt_idx]};
    end

    // Head fields are masked while empty so stale storage never shows after reset.
    assign head        = mem_q[rd_ptr_q];
    assign out_msg     = out_valid ? head[MsgLen-1:0] : '0;
    assign out_chan    = out_valid ? head[CLSB +: CW] : '0;
    assign out_level   = level_q;
    assign drop_count  = dcnt_q;
    assign drop_sticky = sticky_q;

endmodule

// File: tb/tb_msg_arb_queue.sv
// Scenario bench for msg_arb_queue: expected {chan,msg} entries queued at stimulus time
// and retired by a handshake monitor; counters and levels checked inline per task.
module tb_msg_arb_queue;

    logic        clk;
    logic        rst;
    logic [3:0]  in_trigger;
    logic [31:0] in_msg;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_msg;
    logic [1:0]  out_chan;
    logic [2:0]  out_level;
    logic [7:0]  drop_count;
    logic [3:0]  drop_sticky;
    logic        drop_clear;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q [$];
    logic [9:0] mon_exp;

    msg_arb_queue #(
        .ChanCount    (4),
        .MsgLen       (8),
        .Depth        (4),
        .DropCntWidth (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_trigger  (in_trigger),
        .in_msg      (in_msg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_msg     (out_msg),
        .out_chan    (out_chan),
        .out_level   (out_level),
        .drop_count  (drop_count),
        .drop_sticky (drop_sticky),
        .drop_clear  (drop_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output got chan=%0d msg=%h, expected none", out_chan, out_msg);
                miscompares++;
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_chan, out_msg} !== mon_exp) begin
                    $display("FAIL output_order got chan=%0d msg=%h, expected chan=%0d msg=%h",
                             out_chan, out_msg, mon_exp[9:8], mon_exp[7:0]);
                    miscompares++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_trigger = '0;
        drop_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 50) begin
            $display("FAIL %s_drain_timeout got %0d entries outstanding, expected 0", name, exp_q.size());
            miscompares++;
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        in_msg = 32'hFFFF_FFFF;
        rst = 1'b1;
        drop_clear = 1'b0;
        in_trigger = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        in_trigger = '0;
        vectors++;
        if ({out_valid, out_msg, out_chan, out_level, drop_count, drop_sticky} !== 26'd0) begin
            $display("FAIL reset_state got %h, expected 0",
                     {out_valid, out_msg, out_chan, out_level, drop_count, drop_sticky});
            miscompares++;
        end
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || drop_count !== 8'd0) begin
            $display("FAIL reset_trigger_ignored got valid=%b drops=%0d, expected 0/0", out_valid, drop_count);
            miscompares++;
        end
    endtask

    task automatic test_single(input string name);
        out_ready = 1'b1;
        in_trigger = 4'b0100;
        in_msg[23:16] = 8'hA5;
        exp_q.push_back({2'd2, 8'hA5});
        tick();
        in_trigger = '0;
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL %s_latency1 got valid=%b, expected 0", name, out_valid);
            miscompares++;
        end
        tick();
        vectors++;
        if ({out_valid, out_chan, out_msg, out_level} !== {1'b1, 2'd2, 8'hA5, 3'd1}) begin
            $display("FAIL %s_head got v=%b ch=%0d msg=%h lvl=%0d, expected 1/2/a5/1",
                     name, out_valid, out_chan, out_msg, out_level);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_level !== 3'd0 || exp_q.size() != 0) begin
            $display("FAIL %s_empty got v=%b lvl=%0d pend=%0d, expected 0/0/0",
                     name, out_valid, out_level, exp_q.size());
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            in_trigger = 4'hF;
            in_msg = 32'h1312_1110;
            for (int c = 0; c < 4; c++) exp_q.push_back({2'(c), 8'(8'h10 + c)});
            tick();
            in_trigger = '0;
            for (int c = 0; c < 4; c++) begin
                tick();
                vectors++;
                if (out_valid !== 1'b1 || out_chan !== 2'(c)) begin
                    $display("FAIL rr_burst%0d_slot%0d got v=%b ch=%0d, expected 1/%0d",
                             b, c, out_valid, out_chan, c);
                    miscompares++;
                end
            end
            wait_drain("rr");
        end
        vectors++;
        if (drop_count !== 8'd0 || drop_sticky !== 4'd0) begin
            $display("FAIL rr_no_drops got cnt=%0d sticky=%b, expected 0/0000", drop_count, drop_sticky);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_trigger = 4'b0010;
            in_msg[15:8] = 8'(8'h30 + k);
            if (k < 5) exp_q.push_back({2'd1, 8'(8'h30 + k)});
            tick();
        end
        in_trigger = '0;
        vectors++;
        if ({out_level, drop_count, drop_sticky} !== {3'd4, 8'd1, 4'b0010}) begin
            $display("FAIL backpressure_state got lvl=%0d cnt=%0d sticky=%b, expected 4/1/0010",
                     out_level, drop_count, drop_sticky);
            miscompares++;
        end
        out_ready = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_full_push_pop();
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_trigger = 4'b0001;
            in_msg[7:0] = 8'(8'h40 + k);
            exp_q.push_back({2'd0, 8'(8'h40 + k)});
            tick();
        end
        in_trigger = '0;
        tick();
        vectors++;
        if (out_level !== 3'd4 || out_msg !== 8'h40) begin
            $display("FAIL full_before got lvl=%0d head=%h, expected 4/40", out_level, out_msg);
            miscompares++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_level !== 3'd4 || out_msg !== 8'h41 || drop_count !== 8'd0) begin
            $display("FAIL full_push_pop got lvl=%0d head=%h cnt=%0d, expected 4/41/0",
                     out_level, out_msg, drop_count);
            miscompares++;
        end
        out_ready = 1'b1;
        wait_drain("full_push_pop");
    endtask

    task automatic test_drop_counter();
        reset_dut();
        out_ready = 1'b0;
        in_trigger = 4'b0001;
        repeat (5) tick();
        in_trigger = 4'b1110;
        tick();
        in_trigger = 4'hF;
        tick();
        vectors++;
        if (drop_count !== 8'd4 || drop_sticky !== 4'hF) begin
            $display("FAIL multi_drop got cnt=%0d sticky=%b, expected 4/1111", drop_count, drop_sticky);
            miscompares++;
        end
        in_trigger = '0;
        drop_clear = 1'b1;
        tick();
        drop_clear = 1'b0;
        vectors++;
        if (drop_count !== 8'd0 || drop_sticky !== 4'h0) begin
            $display("FAIL drop_clear got cnt=%0d sticky=%b, expected 0/0000", drop_count, drop_sticky);
            miscompares++;
        end
        in_trigger = 4'b0001;
        repeat (255) tick();
        vectors++;
        if (drop_count !== 8'hFF || drop_sticky !== 4'b0001) begin
            $display("FAIL drop_reach_max got cnt=%0d sticky=%b, expected 255/0001", drop_count, drop_sticky);
            miscompares++;
        end
        tick();
        vectors++;
        if (drop_count !== 8'hFF) begin
            $display("FAIL drop_saturate got cnt=%0d, expected 255", drop_count);
            miscompares++;
        end
        in_trigger = 4'b1000;
        drop_clear = 1'b1;
        tick();
        in_trigger = '0;
        drop_clear = 1'b0;
        vectors++;
        if (drop_count !== 8'd1 || drop_sticky !== 4'b1000) begin
            $display("FAIL clear_with_drop got cnt=%0d sticky=%b, expected 1/1000", drop_count, drop_sticky);
            miscompares++;
        end
        reset_dut();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_trigger = 4'b0001;
            in_msg[7:0] = 8'(8'h50 + k);
            tick();
        end
        in_trigger = 4'b0100;
        in_msg[23:16] = 8'h77;
        tick();
        in_trigger = '0;
        vectors++;
        if (out_level !== 3'd3) begin
            $display("FAIL reset_mid_setup got lvl=%0d, expected 3", out_level);
            miscompares++;
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({out_valid, out_msg, out_chan, out_level, drop_count, drop_sticky} !== 26'd0) begin
            $display("FAIL reset_mid_state got %h, expected 0",
                     {out_valid, out_msg, out_chan, out_level, drop_count, drop_sticky});
            miscompares++;
        end
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                $display("FAIL reset_mid_discard got valid=%b, expected 0", out_valid);
                miscompares++;
            end
        end
        test_single("post_reset");
    endtask

    initial begin
        rst = 1'b1;
        in_trigger = '0;
        in_msg = '0;
        out_ready = 1'b0;
        drop_clear = 1'b0;
        test_reset();
        test_single("single");
        test_round_robin();
        test_backpressure();
        test_full_push_pop();
        test_drop_counter();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
